// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S/TDM clock generator and the serialisers around it.
package i2s_pkg;

    typedef enum logic {WS_I2S, WS_TDM} ws_mode_e;

    typedef enum logic {IDLE, RUN} gen_state_e;

    function automatic int unsigned frame_cycles(input int unsigned sck_div,
                                                 input int unsigned slot_bits,
                                                 input int unsigned num_slots);
        return sck_div * slot_bits * num_slots;
    endfunction

endpackage

// File: rtl/i2s_sck_div.sv
// SCK divider: 50% duty bit clock with registered rise/fall strobes; shared with the receiver.
module i2s_sck_div #(
    parameter int unsigned SCK_DIV = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       start,
    input  logic                       enable,
    output logic [$clog2(SCK_DIV)-1:0] div_cnt,
    output logic                       sck,
    output logic                       sck_rise,
    output logic                       sck_fall
);

    localparam int unsigned DIV_W = $clog2(SCK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCK_DIV / 2);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] div_next;

    assign div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_ONE;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            div_cnt  <= '0;
            sck      <= 1'b0;
            sck_rise <= 1'b0;
            sck_fall <= 1'b0;
        end else if (start) begin
            // The first bit begins on a virtual fall so consumers see a clean bit start.
            div_cnt  <= '0;
            sck      <= 1'b0;
            sck_rise <= 1'b0;
            sck_fall <= 1'b1;
        end else if (enable) begin
            div_cnt  <= div_next;
            sck      <= (div_next >= DIV_HALF);
            sck_rise <= (div_next == DIV_HALF);
            sck_fall <= (div_next == '0);
        end else begin
            sck_rise <= 1'b0;
            sck_fall <= 1'b0;
        end
    end

endmodule

// File: rtl/i2s_tdm_clock_gen.sv
// I2S / TDM bit, word and frame timing generator with run/stop at frame boundaries.
// state | meaning
// IDLE  | outputs parked, indices at reset values, waiting for en_i
// RUN   | clocks running; a latched stop request ends the run at the frame boundary
module i2s_tdm_clock_gen
    import i2s_pkg::*;
#(
    parameter int unsigned SCK_DIV   = 8,
    parameter int unsigned SLOT_BITS = 32,
    parameter int unsigned NUM_SLOTS = 2,
    parameter ws_mode_e    WS_MODE   = WS_I2S,
    parameter logic        WS_POL    = 1'b0,
    parameter logic        WS_EARLY  = 1'b1,
    localparam int unsigned SLOT_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    localparam int unsigned BIT_W    = $clog2(SLOT_BITS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    output logic              sck_o,
    output logic              ws_o,
    output logic              sck_rise_o,
    output logic              sck_fall_o,
    output logic              frame_start_o,
    output logic [SLOT_W-1:0] slot_idx_o,
    output logic [BIT_W-1:0]  bit_idx_o,
    output logic              running_o
);

    localparam int unsigned DIV_W = $clog2(SCK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_MSB   = BIT_W'(SLOT_BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [SLOT_W-1:0] SLOT_HALF = SLOT_W'(NUM_SLOTS / 2);
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
    localparam logic [BIT_W-1:0]  WS_BIT    = WS_EARLY ? BIT_ONE : '0;
    localparam logic              WS_START  = (WS_MODE == WS_TDM && !WS_EARLY) ? ~WS_POL : WS_POL;
    localparam int unsigned FRAME_CYCLES = frame_cycles(SCK_DIV, SLOT_BITS, NUM_SLOTS);

    if ((SCK_DIV % 2) != 0 || SCK_DIV < 2) begin : g_bad_div
        $error("i2s_tdm_clock_gen: SCK_DIV must be even and >= 2");
    end
    if (WS_MODE == WS_I2S && (NUM_SLOTS % 2) != 0) begin : g_bad_slots
        $error("i2s_tdm_clock_gen: I2S word select needs an even NUM_SLOTS");
    end
    if (SLOT_BITS < 2 || NUM_SLOTS < 1 || FRAME_CYCLES < 4) begin : g_bad_frame
        $error("i2s_tdm_clock_gen: SLOT_BITS must be >= 2 and NUM_SLOTS >= 1");
    end

    gen_state_e        state;
    logic              stop_pending;
    logic [DIV_W-1:0]  div_cnt;
    logic              go_start;
    logic              go_stop;
    logic              advance;
    logic              bit_end;
    logic              frame_end;
    logic              run_active;
    logic              ws_next;
    logic [SLOT_W-1:0] slot_succ;

    assign run_active = (state == RUN);
    assign go_start   = (state == IDLE) && en_i;
    assign advance    = run_active && (div_cnt == DIV_LAST);
    assign bit_end    = (bit_idx_o == '0);
    assign frame_end  = advance && bit_end && (slot_idx_o == SLOT_LAST);
    assign go_stop    = frame_end && stop_pending;
    assign slot_succ  = (slot_idx_o == SLOT_LAST) ? '0 : slot_idx_o + SLOT_ONE;

    i2s_sck_div #(.SCK_DIV(SCK_DIV)) u_sck_div (
        .clk      (clk_i),
        .rst      (rst_i),
        .clear    (go_stop),
        .start    (go_start),
        .enable   (run_active),
        .div_cnt  (div_cnt),
        .sck      (sck_o),
        .sck_rise (sck_rise_o),
        .sck_fall (sck_fall_o)
    );

    // Level ws_o takes at the next fall; only consulted when a fall is about to happen.
    always_comb begin
        ws_next = ws_o;
        if (WS_MODE == WS_I2S) begin
            if (bit_idx_o == WS_BIT) begin
                ws_next = (slot_succ < SLOT_HALF) ? WS_POL : ~WS_POL;
            end
        end else begin
            ws_next = WS_POL;
            if (slot_idx_o == SLOT_LAST && bit_idx_o == WS_BIT) begin
                ws_next = ~WS_POL;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            stop_pending  <= 1'b0;
            running_o     <= 1'b0;
            frame_start_o <= 1'b0;
            slot_idx_o    <= '0;
            bit_idx_o     <= BIT_MSB;
            ws_o          <= WS_POL;
        end else begin
            frame_start_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (en_i) begin
                        state         <= RUN;
                        stop_pending  <= 1'b0;
                        running_o     <= 1'b1;
                        frame_start_o <= 1'b1;
                        slot_idx_o    <= '0;
                        bit_idx_o     <= BIT_MSB;
                        ws_o          <= WS_START;
                    end
                end
                RUN: begin
                    stop_pending <= ~en_i;
                    if (go_stop) begin
                        state        <= IDLE;
                        stop_pending <= 1'b0;
                        running_o    <= 1'b0;
                        slot_idx_o   <= '0;
                        bit_idx_o    <= BIT_MSB;
                        ws_o         <= WS_POL;
                    end else if (advance) begin
                        if (bit_end) begin
                            bit_idx_o     <= BIT_MSB;
                            slot_idx_o    <= slot_succ;
                            frame_start_o <= (slot_idx_o == SLOT_LAST);
                        end else begin
                            bit_idx_o <= bit_idx_o - BIT_ONE;
                        end
                        ws_o <= ws_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_tdm_clock_gen.sv
// Directed bench: default I2S instance plus an 8-slot TDM instance, checked against closed-form timing.
module tb_i2s_tdm_clock_gen;
    import i2s_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, en_tdm;
    logic       sck, ws, rise, fall, fs, running;
    logic [0:0] slot;
    logic [4:0] bit_idx;
    logic       t_sck, t_ws, t_rise, t_fall, t_fs, t_running;
    logic [2:0] t_slot;
    logic [3:0] t_bit;

    int total = 0;
    int bad   = 0;

    i2s_tdm_clock_gen dut (
        .clk_i(clk), .rst_i(rst), .en_i(en),
        .sck_o(sck), .ws_o(ws), .sck_rise_o(rise), .sck_fall_o(fall),
        .frame_start_o(fs), .slot_idx_o(slot), .bit_idx_o(bit_idx), .running_o(running)
    );

    i2s_tdm_clock_gen #(
        .SCK_DIV(4), .SLOT_BITS(16), .NUM_SLOTS(8),
        .WS_MODE(WS_TDM), .WS_POL(1'b0), .WS_EARLY(1'b1)
    ) dut_tdm (
        .clk_i(clk), .rst_i(rst), .en_i(en_tdm),
        .sck_o(t_sck), .ws_o(t_ws), .sck_rise_o(t_rise), .sck_fall_o(t_fall),
        .frame_start_o(t_fs), .slot_idx_o(t_slot), .bit_idx_o(t_bit), .running_o(t_running)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; en_tdm = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        total++;
        if ({sck, ws, rise, fall, fs, running} !== 6'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=000000", {sck, ws, rise, fall, fs, running});
        end
        total++;
        if (slot !== 1'b0 || bit_idx !== 5'd31) begin
            bad++; $display("FAIL reset_idx got slot=%0d bit=%0d want slot=0 bit=31", slot, bit_idx);
        end
        total++;
        if ({t_sck, t_ws, t_fs, t_running} !== 4'b0 || t_bit !== 4'd15 || t_slot !== 3'd0) begin
            bad++; $display("FAIL reset_tdm got flags=%b slot=%0d bit=%0d want 0000/0/15",
                            {t_sck, t_ws, t_fs, t_running}, t_slot, t_bit);
        end
    endtask

    task automatic test_start_latency();
        int err;
        en = 1'b1;
        tick();
        total++;
        if ({running, fs, fall, sck, rise} !== 5'b11100 || slot !== 1'b0 || bit_idx !== 5'd31) begin
            bad++; $display("FAIL start_first_cycle got run/fs/fall/sck/rise=%b slot=%0d bit=%0d want 11100/0/31",
                            {running, fs, fall, sck, rise}, slot, bit_idx);
        end
        err = 0;
        for (int i = 1; i < 4; i++) begin
            tick();
            if (rise !== 1'b0 || sck !== 1'b0 || fs !== 1'b0) err++;
        end
        total++;
        if (err != 0) begin
            bad++; $display("FAIL start_early_rise got %0d bad cycles want 0", err);
        end
        tick();
        total++;
        if (rise !== 1'b1 || sck !== 1'b1) begin
            bad++; $display("FAIL start_first_rise got rise=%b sck=%b want 1 1", rise, sck);
        end
    endtask

    task automatic test_default_run();
        int err_sig, err_idx, err_run, first_bad, nfs, first_ws, err_tog, last_tog;
        logic prev_ws;
        int p;
        logic e_sck, e_rise, e_fall, e_fs, e_ws;
        err_sig = 0; err_idx = 0; err_run = 0; first_bad = -1; nfs = 0;
        first_ws = -1; err_tog = 0; last_tog = -1; prev_ws = ws;
        for (int t = 5; t < 4200; t++) begin
            tick();
            p      = t % 512;
            e_sck  = (t % 8) >= 4;
            e_rise = (t % 8) == 4;
            e_fall = (t % 8) == 0;
            e_fs   = p == 0;
            e_ws   = (p >= 248) && (p < 504);
            if ({sck, rise, fall, fs, ws} !== {e_sck, e_rise, e_fall, e_fs, e_ws}) begin
                err_sig++;
                if (first_bad < 0) first_bad = t;
            end
            if (bit_idx !== 5'(31 - (t / 8) % 32) || slot !== 1'((t / 256) % 2)) err_idx++;
            if (running !== 1'b1) err_run++;
            if (fs === 1'b1) nfs++;
            if (ws !== prev_ws) begin
                if (first_ws < 0) first_ws = t;
                if (last_tog >= 0 && (t - last_tog) != 256) err_tog++;
                last_tog = t;
            end
            prev_ws = ws;
        end
        total++;
        if (err_sig != 0) begin
            bad++; $display("FAIL run_waveform got %0d bad cycles (first t=%0d) want 0", err_sig, first_bad);
        end
        total++;
        if (err_idx != 0) begin
            bad++; $display("FAIL run_indices got %0d bad cycles want 0", err_idx);
        end
        total++;
        if (err_run != 0) begin
            bad++; $display("FAIL run_running got %0d low cycles want 0", err_run);
        end
        total++;
        if (nfs != 8) begin
            bad++; $display("FAIL run_frame_count got %0d want 8", nfs);
        end
        total++;
        if (first_ws != 248) begin
            bad++; $display("FAIL run_first_ws got t=%0d want 248", first_ws);
        end
        total++;
        if (err_tog != 0) begin
            bad++; $display("FAIL run_ws_interval got %0d bad intervals want 0", err_tog);
        end
    endtask

    task automatic test_stop_mid_frame();
        int t, err;
        t = 4199;
        while ((t % 512) != 424) begin
            tick();
            t++;
        end
        total++;
        if (slot !== 1'b1 || bit_idx !== 5'd10) begin
            bad++; $display("FAIL stop_point got slot=%0d bit=%0d want 1 10", slot, bit_idx);
        end
        en = 1'b0;
        err = 0;
        while ((t % 512) != 511) begin
            tick();
            t++;
            if (running !== 1'b1 || fs !== 1'b0) err++;
        end
        total++;
        if (err != 0) begin
            bad++; $display("FAIL stop_drain got %0d bad cycles want 0", err);
        end
        tick();
        total++;
        if ({running, sck, ws, rise, fall, fs} !== 6'b0 || slot !== 1'b0 || bit_idx !== 5'd31) begin
            bad++; $display("FAIL stop_idle got flags=%b slot=%0d bit=%0d want 000000/0/31",
                            {running, sck, ws, rise, fall, fs}, slot, bit_idx);
        end
        err = 0;
        repeat (16) begin
            tick();
            if ({running, sck, ws, fs, fall, rise} !== 6'b0) err++;
        end
        total++;
        if (err != 0) begin
            bad++; $display("FAIL stop_stays_idle got %0d bad cycles want 0", err);
        end
    endtask

    task automatic test_cancel_stop();
        int err_fs, err_run, nfs;
        en = 1'b1;
        tick();
        err_fs = 0; err_run = 0; nfs = 0;
        for (int t = 1; t <= 1100; t++) begin
            tick();
            if (fs !== ((t % 512) == 0)) err_fs++;
            if (running !== 1'b1) err_run++;
            if (fs === 1'b1) nfs++;
            if (t == 100) en = 1'b0;
            if (t == 150) en = 1'b1;
        end
        total++;
        if (err_fs != 0 || nfs != 2) begin
            bad++; $display("FAIL cancel_spacing got %0d bad cycles, %0d starts want 0, 2", err_fs, nfs);
        end
        total++;
        if (err_run != 0) begin
            bad++; $display("FAIL cancel_running got %0d low cycles want 0", err_run);
        end
    endtask

    task automatic test_reset_mid_slot();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({sck, ws, rise, fall, fs, running} !== 6'b0 || slot !== 1'b0 || bit_idx !== 5'd31) begin
            bad++; $display("FAIL rst_pulse got flags=%b slot=%0d bit=%0d want 000000/0/31",
                            {sck, ws, rise, fall, fs, running}, slot, bit_idx);
        end
        tick();
        total++;
        if ({running, fs, fall, sck} !== 4'b1110 || bit_idx !== 5'd31) begin
            bad++; $display("FAIL rst_restart got run/fs/fall/sck=%b bit=%0d want 1110/31",
                            {running, fs, fall, sck}, bit_idx);
        end
        repeat (3) tick();
        tick();
        total++;
        if (rise !== 1'b1) begin
            bad++; $display("FAIL rst_restart_rise got %b want 1", rise);
        end
        en = 1'b0;
    endtask

    task automatic test_tdm();
        int err_sig, err_idx, hi_cnt, early_hi, p;
        logic [7:0] seen;
        logic e_sck, e_rise, e_fall, e_fs, e_ws;
        en_tdm = 1'b1;
        tick();
        total++;
        if ({t_running, t_fs, t_fall, t_ws, t_sck} !== 5'b11100 || t_slot !== 3'd0 || t_bit !== 4'd15) begin
            bad++; $display("FAIL tdm_start got run/fs/fall/ws/sck=%b slot=%0d bit=%0d want 11100/0/15",
                            {t_running, t_fs, t_fall, t_ws, t_sck}, t_slot, t_bit);
        end
        err_sig = 0; err_idx = 0; hi_cnt = 0; early_hi = 0; seen = 8'h01;
        for (int t = 1; t < 1536; t++) begin
            tick();
            p      = t % 512;
            e_sck  = (t % 4) >= 2;
            e_rise = (t % 4) == 2;
            e_fall = (t % 4) == 0;
            e_fs   = p == 0;
            e_ws   = p >= 508;
            if ({t_sck, t_rise, t_fall, t_fs, t_ws, t_running} !== {e_sck, e_rise, e_fall, e_fs, e_ws, 1'b1})
                err_sig++;
            if (t_slot !== 3'(p / 64) || t_bit !== 4'(15 - (p / 4) % 16)) err_idx++;
            if (t_ws === 1'b1) begin
                hi_cnt++;
                if (t < 508) early_hi++;
            end
            seen[t_slot] = 1'b1;
        end
        total++;
        if (err_sig != 0) begin
            bad++; $display("FAIL tdm_waveform got %0d bad cycles want 0", err_sig);
        end
        total++;
        if (err_idx != 0) begin
            bad++; $display("FAIL tdm_indices got %0d bad cycles want 0", err_idx);
        end
        total++;
        if (hi_cnt != 12 || early_hi != 0) begin
            bad++; $display("FAIL tdm_ws_pulses got high=%0d early=%0d want 12 0", hi_cnt, early_hi);
        end
        total++;
        if (seen !== 8'hFF) begin
            bad++; $display("FAIL tdm_slot_sweep got %h want ff", seen);
        end
        en_tdm = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; en_tdm = 1'b0;
        test_reset();
        test_start_latency();
        test_default_run();
        test_stop_mid_frame();
        test_cancel_stop();
        test_reset_mid_slot();
        test_tdm();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
